// File: rtl/l1dcache_controller.sv
// ---------------------------------------------------------------------------
// l1dcache_controller
//
// Control FSM and metadata store for a 2-way, write-back, write-allocate L1
// data cache with 32-byte lines. This block holds the tag, valid, dirty and
// LRU arrays. It sequences single-cycle hits, dirty-victim writeback and line
// allocation over the pmem port. It also drives the data-array write enables
// and the data-source select.
//
// Ports
//   clk, rst        clock (rising edge); asynchronous active-high reset
//   mem_address     CPU byte address: offset [4:0], set [4+S_BITS:5], tag above
//   mem_read        load request, held until mem_resp
//   mem_write       store request, held until mem_resp (wins over mem_read)
//   mem_resp        one-cycle request-complete pulse
//   pmem_read       line fill request, held until pmem_resp
//   pmem_write      line writeback request, held until pmem_resp
//   pmem_address    line address with offset bits zero
//   pmem_resp       pmem transaction complete
//   data_we0/1      per-way data-array write enables
//   data_sel        0 = assembler-merged store line, 1 = line from pmem
//   read_way        way selected onto mem_rdata / pmem_wdata
//
// Optional build macro DCACHE_PERF_CNT_EN adds the saturating 32-bit
// hit_count, miss_count and wb_count outputs.
// ---------------------------------------------------------------------------
module l1dcache_controller #(
    parameter int S_BITS   = 3,
    parameter int OFF_BITS = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_address,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        mem_resp,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [31:0] pmem_address,
    input  logic        pmem_resp,
    output logic        data_we0,
    output logic        data_we1,
    output logic        data_sel,
    output logic        read_way
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
    output logic [31:0] wb_count
`endif
);

    localparam int SETS  = 1 << S_BITS;
    localparam int TAG_W = 32 - OFF_BITS - S_BITS;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } state_t;

    state_t state_q, state_d;

    logic [1:0][SETS-1:0] valid_q, valid_d;
    logic [1:0][SETS-1:0] dirty_q, dirty_d;
    logic [SETS-1:0]      lru_q,   lru_d;
    logic [TAG_W-1:0]     tag_q [2][SETS];
    logic [TAG_W-1:0]     tag_d [2][SETS];

    logic [S_BITS-1:0] addr_set;
    logic [TAG_W-1:0]  addr_tag;
    logic              request;
    logic              is_store;
    logic              hit0, hit1, hit;
    logic              hit_way;
    logic              victim;
    logic [1:0]        data_we;

    // The byte offset only matters to the data path, not to metadata.
    logic unused_offset;
    assign unused_offset = ^mem_address[OFF_BITS-1:0];

    assign addr_set = mem_address[OFF_BITS +: S_BITS];
    assign addr_tag = mem_address[OFF_BITS+S_BITS +: TAG_W];
    assign request  = mem_read | mem_write;
    assign is_store = mem_write;

    assign hit0    = valid_q[0][addr_set] && (tag_q[0][addr_set] == addr_tag);
    assign hit1    = valid_q[1][addr_set] && (tag_q[1][addr_set] == addr_tag);
    assign hit     = hit0 | hit1;
    // At most one way can hit, so way 1's hit alone identifies the way.
    assign hit_way = hit1;
    // The LRU bit names the least recently used way, which is the victim.
    // It is derived from the live address, which the requester holds stable.
    assign victim  = lru_q[addr_set];

    assign data_we0 = data_we[0];
    assign data_we1 = data_we[1];

    // Next-state, metadata update and output decode.
    // NOTE: combinational logic uses blocking '=' with every target given a
    // default first, so no latch is inferred; state flops use '<=' below.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        lru_d        = lru_q;
        tag_d        = tag_q;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 32'h0;
        data_we      = 2'b00;
        data_sel     = 1'b0;
        read_way     = 1'b0;

        case (state_q)
            IDLE: begin
                if (request) begin
                    if (hit) begin
                        mem_resp        = 1'b1;
                        read_way        = hit_way;
                        lru_d[addr_set] = ~hit_way;
                        if (is_store) begin
                            data_we[hit_way]           = 1'b1;
                            dirty_d[hit_way][addr_set] = 1'b1;
                        end
                    end else if (valid_q[victim][addr_set] && dirty_q[victim][addr_set]) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = ALLOCATE;
                    end
                end
            end

            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[victim][addr_set], addr_set, {OFF_BITS{1'b0}}};
                read_way     = victim;
                if (pmem_resp) begin
                    dirty_d[victim][addr_set] = 1'b0;
                    state_d                   = ALLOCATE;
                end
            end

            ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {addr_tag, addr_set, {OFF_BITS{1'b0}}};
                if (pmem_resp) begin
                    // Install the line; the request, if still held, is then
                    // served as an ordinary hit from IDLE.
                    data_we[victim]           = 1'b1;
                    data_sel                  = 1'b1;
                    tag_d[victim][addr_set]   = addr_tag;
                    valid_d[victim][addr_set] = 1'b1;
                    dirty_d[victim][addr_set] = 1'b0;
                    state_d                   = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
            lru_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            lru_q   <= lru_d;
        end
    end

    // NOTE: the tag array is deliberately left out of reset; a cleared valid
    // bit already makes any stale tag unobservable.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_count_q,  hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;
    logic [31:0] wb_count_q,   wb_count_d;
    logic        hit_inc, miss_inc, wb_inc;

    assign hit_inc  = (state_q == IDLE) && request && hit;
    assign miss_inc = (state_q == IDLE) && request && !hit;
    assign wb_inc   = (state_q == WRITEBACK) && pmem_resp;

    // Saturating increments: a counter holds at all-ones.
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        wb_count_d   = wb_count_q;
        if (hit_inc  && (hit_count_q  != 32'hFFFF_FFFF)) hit_count_d  = hit_count_q  + 32'd1;
        if (miss_inc && (miss_count_q != 32'hFFFF_FFFF)) miss_count_d = miss_count_q + 32'd1;
        if (wb_inc   && (wb_count_q   != 32'hFFFF_FFFF)) wb_count_d   = wb_count_q   + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_q  <= 32'h0;
            miss_count_q <= 32'h0;
            wb_count_q   <= 32'h0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            wb_count_q   <= wb_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
    assign wb_count   = wb_count_q;
`endif

endmodule

// File: tb/tb_l1dcache_controller.sv
// ---------------------------------------------------------------------------
// tb_l1dcache_controller
//
// Self-checking bench for l1dcache_controller. A behavioural model of the
// cache metadata predicts, per request, the ordered pmem writeback, line fill
// and final response events. These are pushed to a scoreboard queue and
// popped as the DUT produces them. The bench also plays the pmem side with a
// per-request response latency.
// ---------------------------------------------------------------------------
module tb_l1dcache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic        mem_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic        pmem_resp;
    logic        data_we0;
    logic        data_we1;
    logic        data_sel;
    logic        read_way;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_count, miss_count, wb_count;
`endif

    always #5 clk = ~clk;

    l1dcache_controller dut (
        .clk          (clk),
        .rst          (rst),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_resp     (mem_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_resp    (pmem_resp),
        .data_we0     (data_we0),
        .data_we1     (data_we1),
        .data_sel     (data_sel),
        .read_way     (read_way)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count),
        .wb_count     (wb_count)
`endif
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, want);
    endtask

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    typedef enum int {EV_WB, EV_FILL, EV_RESP} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [31:0] addr;
        logic        way;
        logic        store;
        int          cycles;
    } exp_t;

    exp_t exp_q[$];

    logic        m_valid [2][8];
    logic        m_dirty [2][8];
    logic [23:0] m_tag   [2][8];
    logic        m_lru   [8];
    int          m_hits, m_misses, m_wbs;

    task automatic model_reset();
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 8; s++) begin
                m_valid[w][s] = 1'b0;
                m_dirty[w][s] = 1'b0;
                m_tag[w][s]   = 24'h0;
            end
        for (int s = 0; s < 8; s++) m_lru[s] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
        m_wbs    = 0;
    endtask

    // Predicts the events of one request; with_resp=0 models a request
    // dropped during the miss (line installed, no response).
    task automatic model_request(input logic [31:0] addr, input logic store,
                                 input int lat, input bit with_resp);
        logic [2:0]  s;
        logic [23:0] t;
        logic        w, v;
        bit          hit;
        int          cyc;
        s   = addr[7:5];
        t   = addr[31:8];
        hit = 0;
        w   = 1'b0;
        for (int i = 0; i < 2; i++)
            if (m_valid[i][s] && m_tag[i][s] == t) begin
                hit = 1;
                w   = i[0];
            end
        cyc = 1;
        if (!hit) begin
            v = m_lru[s];
            m_misses++;
            cyc = lat + 2;
            if (m_valid[v][s] && m_dirty[v][s]) begin
                exp_q.push_back('{kind: EV_WB, addr: {m_tag[v][s], s, 5'b0}, way: v, store: 1'b0, cycles: 0});
                m_wbs++;
                cyc = 2 * lat + 2;
            end
            exp_q.push_back('{kind: EV_FILL, addr: {t, s, 5'b0}, way: v, store: 1'b0, cycles: 0});
            m_tag[v][s]   = t;
            m_valid[v][s] = 1'b1;
            m_dirty[v][s] = 1'b0;
            w = v;
        end
        if (with_resp) begin
            exp_q.push_back('{kind: EV_RESP, addr: 32'h0, way: w, store: store, cycles: cyc});
            m_hits++;
            if (store) m_dirty[w][s] = 1'b1;
            m_lru[s] = ~w;
        end
    endtask

    task automatic pop_exp(input ev_kind_t kind, output exp_t e);
        if (exp_q.size() == 0) begin
            check("scoreboard_underflow", exp_q.size(), 1);
            e = '{kind: kind, addr: 32'h0, way: 1'b0, store: 1'b0, cycles: 0};
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus: one CPU request, with the bench acting as pmem
    // ------------------------------------------------------------------
    task automatic access(input logic [31:0] addr, input logic rd, input logic wr, input int lat);
        exp_t e;
        int   cyc  = 0;
        int   pcnt = 0;
        bit   done = 0;
        model_request(addr, wr, lat, 1);
        @(posedge clk); #1;
        mem_address = addr;
        mem_read    = rd;
        mem_write   = wr;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (mem_resp) begin
                pop_exp(EV_RESP, e);
                check("resp_latency", cyc, e.cycles);
                check("resp_way", read_way, e.way);
                check("resp_we", {data_we1, data_we0}, e.store ? (e.way ? 32'd2 : 32'd1) : 32'd0);
                check("resp_sel", data_sel, 0);
                check("resp_pmem_idle", {pmem_read, pmem_write}, 0);
                done = 1;
            end else if (pmem_read || pmem_write) begin
                if (pcnt == 0) begin
                    pop_exp(pmem_write ? EV_WB : EV_FILL, e);
                    check("pmem_address", pmem_address, e.addr);
                    check("pmem_exclusive", pmem_read & pmem_write, 0);
                    if (pmem_write) check("wb_read_way", read_way, e.way);
                end
                pcnt++;
                if (pcnt == lat) begin
                    pmem_resp = 1'b1;
                    #1;
                    if (pmem_read) begin
                        check("fill_we", {data_we1, data_we0}, e.way ? 32'd2 : 32'd1);
                        check("fill_sel", data_sel, 1);
                    end
                    @(posedge clk); #1;
                    pmem_resp = 1'b0;
                    pcnt      = 0;
                end
            end
        end
        check("resp_seen", done, 1);
        @(posedge clk); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // A load that drops its request during ALLOCATE: the line must still be
    // installed, and no response may follow.
    task automatic drop_during_fill(input logic [31:0] addr, input int lat);
        exp_t e;
        int   pcnt = 0;
        bit   filled = 0;
        model_request(addr, 1'b0, lat, 0);
        @(posedge clk); #1;
        mem_address = addr;
        mem_read    = 1'b1;
        for (int c = 0; c < 30 && !filled; c++) begin
            @(negedge clk);
            check("drop_no_resp", mem_resp, 0);
            if (pmem_read) begin
                if (pcnt == 0) begin
                    pop_exp(EV_FILL, e);
                    check("drop_fill_address", pmem_address, e.addr);
                    mem_read = 1'b0;
                end
                pcnt++;
                if (pcnt == lat) begin
                    pmem_resp = 1'b1;
                    #1;
                    check("drop_fill_we", {data_we1, data_we0}, e.way ? 32'd2 : 32'd1);
                    @(posedge clk); #1;
                    pmem_resp = 1'b0;
                    filled    = 1;
                end
            end
        end
        check("drop_fill_done", filled, 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("drop_quiet", {mem_resp, pmem_read, pmem_write}, 0);
        end
    endtask

    // Reset asserted while a fill is outstanding.
    task automatic reset_during_fill(input logic [31:0] addr);
        bit seen = 0;
        @(posedge clk); #1;
        mem_address = addr;
        mem_read    = 1'b1;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge clk);
            seen = pmem_read;
        end
        check("rst_fill_started", seen, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_async_outputs",
              {pmem_address[29:0], mem_resp, pmem_read, pmem_write, data_we0, data_we1, data_sel, read_way}
              >> 0, 32'h0);
        check("rst_pmem_read", pmem_read, 0);
        mem_read = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        rst         = 1'b1;
        mem_address = 32'h0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        pmem_resp   = 1'b0;
        model_reset();
        #12;
        check("reset_outputs",
              {pmem_address[24:0], mem_resp, pmem_read, pmem_write, data_we0, data_we1, data_sel, read_way},
              32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Stray pmem_resp in IDLE must be ignored.
        pmem_resp = 1'b1;
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        @(negedge clk);
        check("idle_pmem_resp_ignored", {mem_resp, pmem_read, pmem_write, data_we0, data_we1}, 0);

        access(32'h0000_0040, 1'b1, 1'b0, 3);   // cold load, fill way 0
        access(32'h0000_0044, 1'b0, 1'b1, 3);   // store hit way 0, dirties it
        access(32'h0000_1040, 1'b1, 1'b0, 2);   // fill way 1
        access(32'h0000_2040, 1'b1, 1'b0, 2);   // dirty way 0 evicted
        access(32'h0000_1040, 1'b1, 1'b0, 2);   // hit way 1 -> lru 0
        access(32'h0000_2040, 1'b1, 1'b0, 2);   // hit way 0 -> lru 1
        access(32'h0000_3040, 1'b1, 1'b0, 1);   // evicts way 1, one-cycle pmem
        access(32'h0000_3044, 1'b1, 1'b1, 1);   // read+write treated as store

        drop_during_fill(32'h0000_00A0, 2);
        access(32'h0000_00A0, 1'b1, 1'b0, 2);   // installed line now hits

        reset_during_fill(32'h0000_0080);
        access(32'h0000_0080, 1'b1, 1'b0, 2);   // misses after reset
        access(32'h0000_0040, 1'b1, 1'b0, 2);   // previously valid line misses

        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            logic        st;
            a  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 5) | $urandom_range(0, 31);
            st = $urandom_range(0, 1);
            access(a, ~st | $urandom_range(0, 1), st, $urandom_range(1, 4));
        end

        check("scoreboard_drained", exp_q.size(), 0);
`ifdef DCACHE_PERF_CNT_EN
        check("hit_count", hit_count, m_hits);
        check("miss_count", miss_count, m_misses);
        check("wb_count", wb_count, m_wbs);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
